// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : PC owner and ROM requester; buffers responses and hands {pc, instr} to decode.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] PC_RESET   = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ready,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr,
    output logic        o_if_valid,
    input  logic        i_id_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_OCC_W = c_CNT_W + 1;
    localparam logic [c_OCC_W-1:0] c_DEPTH_OCC = c_OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_req_pc;
    logic               r_inflight;

    logic [31:0]        r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]        r_fifo_instr [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [31:0]        w_target;
    logic [c_OCC_W-1:0] w_occ;
    logic               w_pop;
    logic               w_push;
    logic               w_credit;
    logic               w_req;

    assign w_target = i_redirect_pc & ~32'h0000_0003;

    // A redirect clears the FIFO, so a same-cycle pop must not also advance it.
    assign w_pop    = o_if_valid && i_id_ready && !i_redirect;
    assign w_push   = i_mem_valid && r_inflight && (r_state != S_FLUSH) && !i_redirect;

    // Outstanding request counts against space so a response always has a slot.
    assign w_occ    = c_OCC_W'(r_count) + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);
    assign w_credit = (w_occ < c_DEPTH_OCC);
    assign w_req    = (r_state == S_RUN) && w_credit && !i_redirect;

    assign o_mem_addr  = r_pc;
    assign o_mem_ready = w_req;
    assign o_if_valid  = (r_count != '0);
    assign o_if_pc     = r_fifo_pc[r_rd_ptr];
    assign o_if_instr  = r_fifo_instr[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= PC_RESET;
            r_req_pc   <= PC_RESET;
            r_inflight <= 1'b0;
        end else begin
            if (w_req) begin
                r_inflight <= 1'b1;
                r_req_pc   <= r_pc;
            end else if (i_mem_valid) begin
                r_inflight <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_state <= S_RUN;
                    if (i_redirect) begin
                        r_pc <= w_target;
                    end
                end
                S_RUN, S_FLUSH: begin
                    if (i_redirect) begin
                        r_pc    <= w_target;
                        r_state <= r_inflight ? S_FLUSH : S_RUN;
                    end else begin
                        r_state <= S_RUN;
                        if (w_req) begin
                            r_pc <= r_pc + 32'd4;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_pc[i]    <= 32'd0;
                r_fifo_instr[i] <= 32'd0;
            end
        end else if (i_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]    <= r_req_pc;
                r_fifo_instr[r_wr_ptr] <= i_mem_rdata;
                r_wr_ptr               <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Directed self-checking bench for instr_fetch with a 1-cycle ROM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] c_PC_RST = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    instr_fetch #(
        .PC_RESET   (c_PC_RST),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .o_mem_addr    (mem_addr),
        .o_mem_ready   (mem_ready),
        .i_mem_rdata   (mem_rdata),
        .i_mem_valid   (mem_valid),
        .o_if_pc       (if_pc),
        .o_if_instr    (if_instr),
        .o_if_valid    (if_valid),
        .i_id_ready    (id_ready),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
    endfunction

    // ROM: answers a request sampled at one edge with data at the next.
    always @(posedge clk) begin
        mem_valid <= mem_ready;
        mem_rdata <= rom_word(mem_addr);
    end

    task automatic test_reset();
        rst = 1'b1; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL rst_mem_ready got=%b want=0", mem_ready); end
        total++; if (mem_addr !== c_PC_RST) begin bad++; $display("FAIL rst_mem_addr got=%h want=%h", mem_addr, c_PC_RST); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_if_valid got=%b want=0", if_valid); end
        total++; if (if_pc !== 32'd0) begin bad++; $display("FAIL rst_if_pc got=%h want=0", if_pc); end
        total++; if (if_instr !== 32'd0) begin bad++; $display("FAIL rst_if_instr got=%h want=0", if_instr); end
    endtask

    // Release reset with decode ready; c counts rising edges after release.
    task automatic test_stream();
        logic [31:0] exp;
        @(posedge clk); #1; rst = 1'b0; id_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            if (c == 0) begin
                total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL stream_idle_req got=%b want=0", mem_ready); end
            end else begin
                exp = c_PC_RST + 32'(4 * (c - 1));
                total++; if (mem_ready !== 1'b1 || mem_addr !== exp) begin
                    bad++; $display("FAIL stream_req c=%0d got=%b/%h want=1/%h", c, mem_ready, mem_addr, exp);
                end
            end
            if (c < 3) begin
                total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid c=%0d got=%b want=0", c, if_valid); end
            end else begin
                exp = c_PC_RST + 32'(4 * (c - 3));
                total++; if (if_valid !== 1'b1 || if_pc !== exp || if_instr !== rom_word(exp)) begin
                    bad++; $display("FAIL stream_out c=%0d got=%b/%h/%h want=1/%h/%h", c, if_valid, if_pc, if_instr, exp, rom_word(exp));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        exp = c_PC_RST + 32'd32;
        @(posedge clk); #1; id_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if (if_valid !== 1'b1 || if_pc !== exp) begin
                bad++; $display("FAIL stall_hold i=%0d got=%b/%h want=1/%h", i, if_valid, if_pc, exp);
            end
            total++; if (mem_ready !== 1'b0 || mem_addr !== exp + 32'd8) begin
                bad++; $display("FAIL stall_req i=%0d got=%b/%h want=0/%h", i, mem_ready, mem_addr, exp + 32'd8);
            end
        end
        @(posedge clk); #1; id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if (if_valid !== 1'b1 || if_pc !== exp || if_instr !== rom_word(exp)) begin
                bad++; $display("FAIL stall_release i=%0d got=%b/%h/%h want=1/%h/%h", i, if_valid, if_pc, if_instr, exp, rom_word(exp));
            end
            exp = exp + 32'd4;
            @(posedge clk);
        end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] exp;
        int seen;
        @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h0000_0100;
        @(negedge clk);
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL redir_no_req got=%b want=0", mem_ready); end
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk);
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_flushed got=%b want=0", if_valid); end
        exp = 32'h0000_0100; seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if_valid === 1'b1) begin
                total++; if (if_pc !== exp || if_instr !== rom_word(exp)) begin
                    bad++; $display("FAIL redir_stream n=%0d got=%h/%h want=%h/%h", seen, if_pc, if_instr, exp, rom_word(exp));
                end
                exp = exp + 32'd4; seen++;
            end
        end
        total++; if (seen < 5) begin bad++; $display("FAIL redir_count got=%0d want>=5", seen); end
    endtask

    task automatic test_redirect_unaligned();
        bit got_req, got_out;
        @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h0000_0203;
        @(posedge clk); #1; redirect = 1'b0;
        got_req = 1'b0; got_out = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!got_req && mem_ready === 1'b1) begin
                got_req = 1'b1;
                total++; if (mem_addr !== 32'h0000_0200) begin bad++; $display("FAIL unal_addr got=%h want=00000200", mem_addr); end
            end
            if (!got_out && if_valid === 1'b1) begin
                got_out = 1'b1;
                total++; if (if_pc !== 32'h0000_0200 || if_instr !== rom_word(32'h0000_0200)) begin
                    bad++; $display("FAIL unal_pc got=%h/%h want=00000200/%h", if_pc, if_instr, rom_word(32'h0000_0200));
                end
            end
        end
        total++; if (!got_req || !got_out) begin bad++; $display("FAIL unal_timeout got=%b%b want=11", got_req, got_out); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_req, exp_pc;
        int nreq, nout;
        @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1; redirect = 1'b0;
        exp_req = 32'hFFFF_FFFC; exp_pc = 32'hFFFF_FFFC; nreq = 0; nout = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                total++; if (mem_addr !== exp_req) begin bad++; $display("FAIL wrap_req n=%0d got=%h want=%h", nreq, mem_addr, exp_req); end
                exp_req = exp_req + 32'd4; nreq++;
            end
            if (if_valid === 1'b1) begin
                total++; if (if_pc !== exp_pc || if_instr !== rom_word(exp_pc)) begin
                    bad++; $display("FAIL wrap_out n=%0d got=%h/%h want=%h/%h", nout, if_pc, if_instr, exp_pc, rom_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4; nout++;
            end
        end
        total++; if (nreq < 3 || nout < 3) begin bad++; $display("FAIL wrap_count got=%0d/%0d want>=3/3", nreq, nout); end
    endtask

    // Reset hits while the credit limit is reached and a response is pending;
    // the ROM answer that lands after reset must be ignored.
    task automatic test_reset_midstream();
        logic [31:0] exp;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (if_valid !== 1'b0 || mem_ready !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs got=%b/%b want=0/0", if_valid, mem_ready);
        end
        total++; if (mem_addr !== c_PC_RST || if_pc !== 32'd0) begin
            bad++; $display("FAIL midrst_regs got=%h/%h want=%h/0", mem_addr, if_pc, c_PC_RST);
        end
        #1; rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c <= 3) begin
                exp = c_PC_RST + 32'(4 * (c - 1));
                total++; if (mem_ready !== 1'b1 || mem_addr !== exp) begin
                    bad++; $display("FAIL midrst_req c=%0d got=%b/%h want=1/%h", c, mem_ready, mem_addr, exp);
                end
            end
            if (c < 3) begin
                total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL midrst_spurious c=%0d got=%b want=0", c, if_valid); end
            end else begin
                exp = c_PC_RST + 32'(4 * (c - 3));
                total++; if (if_valid !== 1'b1 || if_pc !== exp || if_instr !== rom_word(exp)) begin
                    bad++; $display("FAIL midrst_out c=%0d got=%b/%h want=1/%h", c, if_valid, if_pc, exp);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        mem_valid = 1'b0; mem_rdata = 32'd0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_unaligned();
        test_wrap();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
